// File: rtl/delay_line_sampler.sv
// Host-side sequencer for the delay-line tile: resets it, runs N launch/settle/capture/clear
// rounds, decodes each thermometer capture and returns the summed tap count with an error flag.
module delay_line_sampler #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned RST_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_cmd_samples,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [15:0] o_res_sum,
    output logic        o_res_err,
    output logic        o_dut_rst_n,
    output logic        o_dut_ena,
    output logic [7:0]  o_dut_ui_in,
    input  logic [7:0]  i_dut_uo_out
);

    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StDrst, StIdle, StLaunch, StSettle, StSample, StClear, StDone
    } state_e;

    state_e      r_state, w_state_next;
    logic [RstW-1:0] r_rst_cnt, w_rst_cnt_next;
    logic [SetW-1:0] r_settle_cnt, w_settle_cnt_next;
    logic [8:0]  r_remain, w_remain_next;
    logic [15:0] r_sum, w_sum_next;
    logic        r_err, w_err_next;
    logic [7:0]  r_sync1, r_sync2;
    logic [7:0]  r_ui_in, w_ui_in_next;
    logic [3:0]  w_pop;
    logic        w_code_valid;

    // A thermometer code plus one is a power of two (or wraps to zero for 0xFF).
    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'b000, r_sync2[i]};
        end
        w_code_valid = ((r_sync2 & (r_sync2 + 8'd1)) == 8'd0);
    end

    always_comb begin
        w_state_next      = r_state;
        w_rst_cnt_next    = r_rst_cnt;
        w_settle_cnt_next = r_settle_cnt;
        w_remain_next     = r_remain;
        w_sum_next        = r_sum;
        w_err_next        = r_err;
        unique case (r_state)
            StDrst: begin
                if (r_rst_cnt == RstW'(RST_CYCLES - 1)) begin
                    w_state_next = StIdle;
                end else begin
                    w_rst_cnt_next = r_rst_cnt + 1'b1;
                end
            end
            StIdle: begin
                if (i_cmd_valid) begin
                    w_remain_next = {(i_cmd_samples == 8'd0), i_cmd_samples};
                    w_sum_next    = 16'd0;
                    w_err_next    = 1'b0;
                    w_state_next  = StLaunch;
                end
            end
            StLaunch: begin
                w_settle_cnt_next = '0;
                w_state_next      = StSettle;
            end
            StSettle: begin
                if (r_settle_cnt == SetW'(SETTLE_CYCLES - 1)) begin
                    w_state_next = StSample;
                end else begin
                    w_settle_cnt_next = r_settle_cnt + 1'b1;
                end
            end
            StSample: begin
                w_sum_next = r_sum + {12'd0, w_pop};
                if (!w_code_valid) begin
                    w_err_next = 1'b1;
                end
                w_state_next = StClear;
            end
            StClear: begin
                w_remain_next = r_remain - 9'd1;
                w_state_next  = (r_remain == 9'd1) ? StDone : StLaunch;
            end
            StDone: begin
                if (i_res_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StDrst;
        endcase
    end

    // Pulses are registered from the next state so they line up with LAUNCH/CLEAR exactly.
    always_comb begin
        w_ui_in_next = {6'd0, (w_state_next == StClear), (w_state_next == StLaunch)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StDrst;
            r_rst_cnt    <= '0;
            r_settle_cnt <= '0;
            r_remain     <= 9'd0;
            r_sum        <= 16'd0;
            r_err        <= 1'b0;
            r_sync1      <= 8'd0;
            r_sync2      <= 8'd0;
            r_ui_in      <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_rst_cnt    <= w_rst_cnt_next;
            r_settle_cnt <= w_settle_cnt_next;
            r_remain     <= w_remain_next;
            r_sum        <= w_sum_next;
            r_err        <= w_err_next;
            r_sync1      <= i_dut_uo_out;
            r_sync2      <= r_sync1;
            r_ui_in      <= w_ui_in_next;
        end
    end

    assign o_cmd_ready = (r_state == StIdle);
    assign o_res_valid = (r_state == StDone);
    assign o_res_sum   = r_sum;
    assign o_res_err   = r_err;
    assign o_dut_rst_n = (r_state != StDrst);
    assign o_dut_ena   = (r_state != StDrst);
    assign o_dut_ui_in = r_ui_in;

endmodule

// File: tb/tb_delay_line_sampler.sv
// Bench for delay_line_sampler: behavioural tile model, vector table and scoreboard queue,
// plus reset, stalled-result and mid-run-abort sequences.
module tb_delay_line_sampler;

    localparam int S   = 4;
    localparam int R   = 8;
    localparam int PER = S + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_samples = 8'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_sum;
    logic        res_err;
    logic        dut_rst_n;
    logic        dut_ena;
    logic [7:0]  dut_ui_in;
    logic [7:0]  dut_uo_out = 8'd0;

    int checks = 0;
    int errors = 0;

    delay_line_sampler #(
        .SETTLE_CYCLES(S),
        .RST_CYCLES   (R)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_samples(cmd_samples),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_sum    (res_sum),
        .o_res_err    (res_err),
        .o_dut_rst_n  (dut_rst_n),
        .o_dut_ena    (dut_ena),
        .o_dut_ui_in  (dut_ui_in),
        .i_dut_uo_out (dut_uo_out)
    );

    always #5 clk = ~clk;

    // Tile model: each launch presents the next code of a 4-entry cyclic pattern; clear zeroes it.
    logic [31:0] cur_codes = 32'd0;
    int code_idx  = 0;
    int code_base = 0;
    int launches  = 0;

    always @(posedge clk) begin
        if (dut_ui_in[0]) begin
            dut_uo_out <= cur_codes[8*((code_idx - code_base) % 4) +: 8];
            code_idx   <= code_idx + 1;
            launches   <= launches + 1;
        end else if (dut_ui_in[1]) begin
            dut_uo_out <= 8'd0;
        end
    end

    typedef struct packed {
        logic [15:0] sum;
        logic        err;
        int          lat;
        int          nlaunch;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0]  samples;
        logic [31:0] codes;
        int          exp_sum;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL wait_ready: got cmd_ready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic run_cmd(input logic [7:0] n, input logic [31:0] codes, input int esum,
                           input bit eerr, input bit handshake);
        int   nn;
        int   lat;
        int   l0;
        exp_t e;
        @(negedge clk);
        wait_ready();
        nn          = (n == 8'd0) ? 256 : int'(n);
        cur_codes   = codes;
        code_base   = code_idx;
        l0          = launches;
        exp_q.push_back('{sum: 16'(esum), err: eerr, lat: nn * PER + 1, nlaunch: nn});
        cmd_samples = n;
        cmd_valid   = 1'b1;
        lat         = 0;
        while (lat < 3000) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (lat == 1) begin
                check("cleared_at_accept", int'({res_sum, res_err}), 0);
                check("ready_low_in_run", int'(cmd_ready), 0);
            end
            if (res_valid) break;
        end
        if (!res_valid) begin
            errors++;
            $display("FAIL res_timeout: got res_valid 0 expected 1 within 3000 cycles");
            return;
        end
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got result %0d expected none", res_sum);
            return;
        end
        e = exp_q.pop_front();
        check("latency", lat, e.lat);
        check("res_sum", int'(res_sum), int'(e.sum));
        check("res_err", int'(res_err), int'(e.err));
        check("launches", launches - l0, e.nlaunch);
        if (handshake) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("idle_after_hs", int'({cmd_ready, res_valid}), 2);
            check("sum_held_after_hs", int'(res_sum), int'(e.sum));
        end
    endtask

    vec_t vecs[6];

    initial begin
        int first;
        int bad;
        int l0;
        int k;
        bit saw_valid;

        vecs[0] = '{8'd3, 32'h0F0F0F0F, 12,   1'b0};
        vecs[1] = '{8'd0, 32'hFFFFFFFF, 2048, 1'b0};
        vecs[2] = '{8'd4, 32'hFF000507, 13,   1'b1};
        vecs[3] = '{8'd2, 32'h00008001, 2,    1'b1};
        vecs[4] = '{8'd1, 32'h00000000, 0,    1'b0};
        vecs[5] = '{8'd5, 32'h3F3F3F3F, 30,   1'b0};

        // Reset values and DRST length.
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_sum", int'(res_sum), 0);
        check("rst_res_err", int'(res_err), 0);
        check("rst_dut_rst_n", int'(dut_rst_n), 0);
        check("rst_dut_ena", int'(dut_ena), 0);
        check("rst_dut_ui_in", int'(dut_ui_in), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        first = -1;
        bad   = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (cmd_ready && first < 0) first = i;
            if (i < R && (dut_rst_n || dut_ena)) bad++;
        end
        check("ready_after_rst", first, R);
        check("drst_pins_low", bad, 0);

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].samples, vecs[i].codes, vecs[i].exp_sum, vecs[i].exp_err, 1'b1);
        end

        // Result stalled in DONE while cmd_valid toggles.
        run_cmd(8'd1, 32'h05050505, 2, 1'b1, 1'b0);
        l0  = launches;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cmd_valid = i[0];
            @(negedge clk);
            if (res_sum != 16'd2 || res_err != 1'b1 || !res_valid || cmd_ready) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_no_launch", launches - l0, 0);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("stall_hs_ready", int'(cmd_ready), 1);
        check("stall_err_held", int'(res_err), 1);
        run_cmd(8'd1, 32'h03030303, 2, 1'b0, 1'b1);

        // Abort during SETTLE of the second sample.
        @(negedge clk);
        wait_ready();
        cur_codes   = 32'h0F0F0F0F;
        code_base   = code_idx;
        cmd_samples = 8'd3;
        cmd_valid   = 1'b1;
        k = 0;
        while (k < PER + 3) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            k++;
        end
        rst_n = 1'b0;
        #1;
        check("abort_ui_in", int'(dut_ui_in), 0);
        check("abort_dut_rst_n", int'(dut_rst_n), 0);
        check("abort_res_valid", int'(res_valid), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        first     = -1;
        saw_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (cmd_ready && first < 0) first = i;
            if (res_valid) saw_valid = 1'b1;
        end
        check("abort_ready_after", first, R);
        check("abort_no_result", int'(saw_valid), 0);

        run_cmd(8'd2, 32'h01010101, 2, 1'b0, 1'b1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_line_sampler.md
# delay_line_sampler

Host-side driver for the delay-line user module's pin interface: drives its `ui_in`, `rst_n` and `ena` pins, and reads back the 8-bit thermometer code on its `uo_out`. On command, it runs N launch/settle/capture/clear cycles and decodes each thermometer code to a tap count. It accumulates the counts and returns the sum with an error flag over a valid/ready interface. It sits in the FPGA/bench harness on the opposite side of the tile pins.

## Interface
- `SETTLE_CYCLES`, default 4: cycles between the launch pulse and sampling (≥1).
- `RST_CYCLES`, default 8: cycles `dut_rst_n` is held low after local reset (≥1).
- `clk` in 1: single clock; every flop is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_samples` in 8: sample count; 0 means 256.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed.
- `res_sum` out 16: sum of decoded counts.
- `res_err` out 1: at least one non-thermometer code was seen in this run.
- `dut_rst_n` out 1: drives the DUT `rst_n`.
- `dut_ena` out 1: drives the DUT `ena`.
- `dut_ui_in` out 8: bit0 = launch, bit1 = clear, bits 7:2 = 0.
- `dut_uo_out` in 8: thermometer capture from the DUT.

## Operation
- `dut_uo_out` passes through a 2-flop synchronizer that always runs. Its reset value is 0.
- States and transitions:
  - DRST: `dut_rst_n` = 0 for `RST_CYCLES` cycles, then go to IDLE.
  - IDLE: `cmd_ready` = 1. On `cmd_valid`, latch N, clear the sum and error flag, then go to LAUNCH.
  - LAUNCH: `dut_ui_in[0]` = 1 for one cycle, then go to SETTLE.
  - SETTLE: wait `SETTLE_CYCLES` cycles, then go to SAMPLE.
  - SAMPLE: decode the synchronized code, add it to the sum, then go to CLEAR.
  - CLEAR: `dut_ui_in[1]` = 1 for one cycle. Decrement the remaining count. If it reaches 0, go to DONE; otherwise go to LAUNCH.
  - DONE: `res_valid` = 1, holding `res_sum` and `res_err` stable. On `res_ready`, go to IDLE.
- `dut_ena` = 1 in every state except DRST.
- Decode rule: a valid code has bits [k-1:0] = 1 and all higher bits = 0, for k in 0..8.
  - A valid code contributes k.
  - An invalid code contributes its popcount and sets `res_err`, which stays set for the rest of the run.
- Sum arithmetic: unsigned, 16 bits. The maximum is 256×8 = 2048, so it never wraps.
- `res_sum` and `res_err` hold their last values after the handshake until the next command clears them at acceptance.
- `dut_ui_in` is a registered output, so it has no combinational path from the inputs.

## Timing
- Reset values:
  - `cmd_ready` = 0, `res_valid` = 0, `res_sum` = 0, `res_err` = 0.
  - `dut_rst_n` = 0, `dut_ena` = 0, `dut_ui_in` = 0.
  - State = DRST.
- `cmd_ready` rises `RST_CYCLES` cycles after `rst_n` deasserts.
- Command handshake: a command is accepted on the edge where `cmd_valid` and `cmd_ready` are both 1. `cmd_ready` falls the next cycle.
- Per-sample period: exactly `SETTLE_CYCLES` + 3 cycles (LAUNCH 1, SETTLE S, SAMPLE 1, CLEAR 1).
- Command latency: `res_valid` rises N×(S+3) + 1 cycles after acceptance (S = `SETTLE_CYCLES`).
- Result handshake: the result completes on the edge where `res_valid` and `res_ready` are both 1.
  - IDLE and `cmd_ready` = 1 follow on the next cycle.
  - No back-to-back acceptance occurs in the handshake cycle itself.
- `cmd_valid` outside IDLE is ignored; the command is not queued.
- `res_ready` high with no result pending (before DONE) has no effect.
- Asserting `rst_n` mid-run aborts immediately:
  - All outputs return to their reset values.
  - The DUT is re-reset through DRST.
  - No partial result is presented.

## Test plan
- Reset, RST_CYCLES = 8: `dut_rst_n` is low 8 cycles after release, `dut_ena` = 0 until then, then `cmd_ready` = 1.
- `cmd_samples` = 3, DUT model returns 0x0F every time: `res_sum` = 12, `res_err` = 0, `res_valid` at exactly 3×7 + 1 = 22 cycles after acceptance (S = 4).
- `cmd_samples` = 0, code 0xFF: 256 launches counted on `dut_ui_in[0]`, `res_sum` = 2048, `res_err` = 0.
- Codes sequence 0x07, 0x05, 0x00, 0xFF with `cmd_samples` = 4: `res_sum` = 3+2+0+8 = 13, `res_err` = 1.
- `res_ready` held low 50 cycles in DONE while `cmd_valid` toggles: result stays stable, no new launch, `cmd_ready` = 0; after the handshake, the next command clears `res_err` to 0.
- `rst_n` pulsed low during SETTLE of sample 2: `dut_ui_in` = 0, `dut_rst_n` = 0, and `res_valid` = 0 at once; then DRST runs and IDLE resumes with no result.
